// File: rtl/demux_gearbox_param.sv
// demux_gearbox_param
// Serial-to-parallel gearbox: packs RATIO consecutive IN_W-bit lanes into one
// OUT_W-bit word. Lane order, partial-word handling and explicit re-alignment
// are selected by parameters and the align input. Single clock (clk_4f),
// asynchronous active-low reset (reset).
//
// Assembly state (no FSM encoding; idx is the only sequencing state):
//   idx    | meaning
//   0      | no lanes of the current word received yet (idle between words)
//   1..R-1 | that many lanes already packed into acc_q / mask_q

module demux_gearbox_param #(
    parameter int  IN_W          = 8,
    parameter int  RATIO         = 4,
    parameter bit  MSB_FIRST     = 1'b1,
    parameter bit  FLUSH_PARTIAL = 1'b1,
    localparam int OUT_W         = IN_W * RATIO
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             valid,
    input  logic [IN_W-1:0]  data_in,
    input  logic             align,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    output logic [RATIO-1:0] lane_mask,
    output logic             err_partial
);

    localparam int               IDX_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RATIO - 1);
    localparam int               FIRST_SLOT = MSB_FIRST ? (RATIO - 1) : 0;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [RATIO-1:0] mask_q, mask_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic [RATIO-1:0] lane_mask_q, lane_mask_d;
    logic             valid_out_q, valid_out_d;
    logic             err_partial_q, err_partial_d;

    // Output slot that lane k of a word lands in.
    function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] k);
        if (MSB_FIRST) begin
            return LAST_IDX - k;
        end
        return k;
    endfunction

    logic [IDX_W-1:0] cur_slot;
    assign cur_slot = slot_of(idx_q);

    // Next-state: align beats valid, valid beats partial-word termination.
    always_comb begin
        idx_d         = idx_q;
        acc_d         = acc_q;
        mask_d        = mask_q;
        data_out_d    = data_out_q;
        lane_mask_d   = lane_mask_q;
        valid_out_d   = 1'b0;
        err_partial_d = 1'b0;

        if (align) begin
            // Pending partial word is dropped silently.
            acc_d  = '0;
            mask_d = '0;
            idx_d  = '0;
            if (valid) begin
                acc_d[FIRST_SLOT*IN_W +: IN_W] = data_in;
                mask_d[FIRST_SLOT]             = 1'b1;
                idx_d                          = IDX_W'(1);
            end
        end else if (valid) begin
            acc_d[cur_slot*IN_W +: IN_W] = data_in;
            mask_d[cur_slot]             = 1'b1;
            if (idx_q == LAST_IDX) begin
                data_out_d  = acc_d;
                lane_mask_d = '1;
                valid_out_d = 1'b1;
                acc_d       = '0;
                mask_d      = '0;
                idx_d       = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (idx_q != '0) begin
            // A valid gap ends the word; there is no resumption.
            if (FLUSH_PARTIAL) begin
                data_out_d  = acc_q;
                lane_mask_d = mask_q;
                valid_out_d = 1'b1;
            end else begin
                err_partial_d = 1'b1;
            end
            acc_d  = '0;
            mask_d = '0;
            idx_d  = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            idx_q         <= '0;
            acc_q         <= '0;
            mask_q        <= '0;
            data_out_q    <= '0;
            lane_mask_q   <= '0;
            valid_out_q   <= 1'b0;
            err_partial_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            mask_q        <= mask_d;
            data_out_q    <= data_out_d;
            lane_mask_q   <= lane_mask_d;
            valid_out_q   <= valid_out_d;
            err_partial_q <= err_partial_d;
        end
    end

    assign data_out    = data_out_q;
    assign lane_mask   = lane_mask_q;
    assign valid_out   = valid_out_q;
    assign err_partial = err_partial_q;

endmodule

// File: tb/tb_demux_gearbox_param.sv
// Bench for demux_gearbox_param: three instances (defaults, discard mode,
// LSB-first) share one stimulus stream and are compared every cycle against
// a lane-list reference model, plus directed value checks.

module tb_demux_gearbox_param;

    logic        clk_4f = 1'b0;
    logic        reset  = 1'b0;
    logic        valid  = 1'b0;
    logic [7:0]  data_in = '0;
    logic        align  = 1'b0;

    logic [31:0] dout [3];
    logic [3:0]  lmask [3];
    logic        vout [3];
    logic        perr [3];

    int tests  = 0;
    int failed = 0;

    always #5 clk_4f = ~clk_4f;

    demux_gearbox_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1)) u_def (
        .clk_4f(clk_4f), .reset(reset), .valid(valid), .data_in(data_in), .align(align),
        .data_out(dout[0]), .valid_out(vout[0]), .lane_mask(lmask[0]), .err_partial(perr[0]));

    demux_gearbox_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b0)) u_disc (
        .clk_4f(clk_4f), .reset(reset), .valid(valid), .data_in(data_in), .align(align),
        .data_out(dout[1]), .valid_out(vout[1]), .lane_mask(lmask[1]), .err_partial(perr[1]));

    demux_gearbox_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1)) u_lsb (
        .clk_4f(clk_4f), .reset(reset), .valid(valid), .data_in(data_in), .align(align),
        .data_out(dout[2]), .valid_out(vout[2]), .lane_mask(lmask[2]), .err_partial(perr[2]));

    // Reference model: list of lanes received so far for the current word.
    logic [7:0]  m_lanes [3][4];
    int          m_cnt   [3];
    logic [31:0] e_dout  [3];
    logic [3:0]  e_mask  [3];
    logic        e_vout  [3];
    logic        e_err   [3];

    function automatic bit cfg_msb(input int c);
        return (c != 2);
    endfunction

    function automatic bit cfg_flush(input int c);
        return (c != 1);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c]  = 0;
            e_dout[c] = '0;
            e_mask[c] = '0;
            e_vout[c] = 1'b0;
            e_err[c]  = 1'b0;
        end
    endtask

    // Place the received lanes into their output slots.
    task automatic model_emit(input int c);
        logic [31:0] w;
        logic [3:0]  m;
        int          s;
        w = '0;
        m = '0;
        for (int k = 0; k < m_cnt[c]; k++) begin
            s = cfg_msb(c) ? (3 - k) : k;
            w[s*8 +: 8] = m_lanes[c][k];
            m[s] = 1'b1;
        end
        e_dout[c] = w;
        e_mask[c] = m;
        e_vout[c] = 1'b1;
    endtask

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            e_vout[c] = 1'b0;
            e_err[c]  = 1'b0;
            if (align) begin
                m_cnt[c] = 0;
                if (valid) begin
                    m_lanes[c][0] = data_in;
                    m_cnt[c] = 1;
                end
            end else if (valid) begin
                m_lanes[c][m_cnt[c]] = data_in;
                m_cnt[c]++;
                if (m_cnt[c] == 4) begin
                    model_emit(c);
                    m_cnt[c] = 0;
                end
            end else if (m_cnt[c] != 0) begin
                if (cfg_flush(c)) model_emit(c);
                else e_err[c] = 1'b1;
                m_cnt[c] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("data_out[%0d]", c),  dout[c],        e_dout[c]);
            chk($sformatf("lane_mask[%0d]", c), 32'(lmask[c]),  32'(e_mask[c]));
            chk($sformatf("valid_out[%0d]", c), 32'(vout[c]),   32'(e_vout[c]));
            chk($sformatf("err_partial[%0d]", c), 32'(perr[c]), 32'(e_err[c]));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare #1 later.
    task automatic step(input logic v, input logic [7:0] d, input logic a);
        valid   = v;
        data_in = d;
        align   = a;
        @(posedge clk_4f);
        if (reset) model_edge();
        #1;
        check_all();
    endtask

    task automatic stream4(input logic [7:0] a, b, c, d);
        step(1'b1, a, 1'b0);
        step(1'b1, b, 1'b0);
        step(1'b1, c, 1'b0);
        step(1'b1, d, 1'b0);
    endtask

    initial begin
        model_clear();

        // Reset held low for 4 cycles with valid toggling.
        for (int i = 0; i < 4; i++) step(i[0], 8'h5A, 1'b0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Basic stream.
        stream4(8'hEE, 8'hFF, 8'hFD, 8'hCC);
        chk("full_msb", dout[0], 32'hEEFFFDCC);
        chk("full_mask", 32'(lmask[0]), 32'h0000000F);
        chk("full_lsb", dout[2], 32'hCCFDFFEE);
        step(1'b0, 8'h00, 1'b0);
        chk("pulse_one_cycle", 32'(vout[0]), 32'd0);

        // Continuous: two words back to back.
        stream4(8'hAA, 8'h12, 8'hBB, 8'h00);
        chk("cont_w0", dout[0], 32'hAA12BB00);
        stream4(8'h11, 8'h22, 8'h33, 8'h44);
        chk("cont_w1", dout[0], 32'h11223344);
        step(1'b0, 8'h00, 1'b0);

        // Partial word terminated by a valid gap.
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("flush_data", dout[0], 32'hAA120000);
        chk("flush_mask", 32'(lmask[0]), 32'h0000000C);
        chk("disc_err", 32'(perr[1]), 32'd1);
        chk("disc_hold", dout[1], 32'h11223344);

        // Align restarts assembly; dropped partial gives no pulse.
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h55, 1'b1);
        step(1'b1, 8'h66, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h88, 1'b0);
        chk("align_word", dout[0], 32'h55667788);

        // Align on the last lane loses the pending word.
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h04, 1'b1);
        chk("align_last_nopulse", 32'(vout[0]), 32'd0);
        stream4(8'h05, 8'h06, 8'h07, 8'h00);
        step(1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-word.
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        #2 reset = 1'b0;
        #1 model_clear();
        check_all();
        step(1'b1, 8'h99, 1'b0);
        reset = 1'b1;
        stream4(8'hEE, 8'hFF, 8'hFD, 8'hCC);
        chk("post_reset_word", dout[0], 32'hEEFFFDCC);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic v, a;
            v = ($urandom_range(0, 99) < 75);
            a = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                #1 model_clear();
                check_all();
                step(v, 8'($urandom), a);
                reset = 1'b1;
            end else begin
                step(v, 8'($urandom), a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/demux_gearbox_param.md
# demux_gearbox_param

Parametrised serial-to-parallel gearbox for the PCI physical-layer receive path. It is the single-clock successor of the fixed 8→32 demux. It packs RATIO consecutive valid IN_W-bit lanes into one IN_W·RATIO-bit word, with these additions:
- selectable lane order;
- flush or discard of partial words when `valid` drops mid-word;
- an explicit `align` input that restarts word assembly.

## Interface
Parameters:
- IN_W, 8, width of each input lane in bits (≥1)
- RATIO, 4, lanes per output word (≥2); output width OUT_W = IN_W·RATIO
- MSB_FIRST, 1, 1: first lane lands in the most-significant slot; 0: first lane lands in the least-significant slot
- FLUSH_PARTIAL, 1, 1: emit zero-padded partial words; 0: discard them and flag an error

Ports:
- clk_4f  in  1  sole clock, lane rate; all logic on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- valid  in  1  data_in carries a lane this cycle
- data_in  in  IN_W  input lane
- align  in  1  restart word assembly at lane 0
- data_out  out  OUT_W  last emitted word, held until the next emission
- valid_out  out  1  one-cycle pulse when data_out is updated
- lane_mask  out  RATIO  bit j set ⇔ data_out[j·IN_W +: IN_W] holds received data
- err_partial  out  1  one-cycle pulse when a partial word is discarded

## Operation
- State:
  - lane index idx, 0..RATIO-1, width ceil(log2 RATIO);
  - OUT_W accumulator;
  - RATIO-bit fill mask.
- Slot mapping for lane k:
  - MSB_FIRST=1: slot RATIO-1-k;
  - MSB_FIRST=0: slot k.
- Per-cycle priority, highest first:
  - **align=1.**
    - Clear the accumulator and fill mask, then set idx=0.
    - If valid=1 in the same cycle, take data_in as lane 0 and set idx=1.
    - No valid_out and no err_partial for the discarded partial word.
  - **valid=1.**
    - Write data_in into the slot for lane idx and set the matching fill-mask bit.
    - If idx=RATIO-1: emit the full word next edge with lane_mask all ones. Clear the accumulator and mask, and wrap idx to 0.
    - Otherwise: idx+1.
  - **valid=0 and idx≠0 (partial word).**
    - FLUSH_PARTIAL=1: emit the accumulator with unfilled slots zero and lane_mask equal to the fill mask.
    - FLUSH_PARTIAL=0: pulse err_partial. data_out and lane_mask remain unchanged.
    - Either way, clear the state and set idx=0.
  - **valid=0 and idx=0:** idle, no change.
- Emission means data_out, lane_mask and valid_out=1 are all registered on the same edge.
- valid_out and err_partial are never high in the same cycle.

## Timing
- Reset values:
  - data_out=0, lane_mask=0, valid_out=0, err_partial=0;
  - idx=0, accumulator=0, fill mask=0.
- Latency:
  - A full word appears (valid_out=1) in the cycle after the clock edge that samples its last lane.
  - A partial flush appears in the cycle after the edge that samples valid=0.
- Throughput: continuous valid=1 gives one valid_out pulse every RATIO cycles with no bubbles.
- Boundary conditions:
  - A one-cycle valid gap mid-word terminates the word; there is no resumption.
  - align on the cycle idx=RATIO-1 with valid=1 loses the pending word; that lane becomes lane 0 of a new word.
  - Asserting reset mid-word discards all state with no pulse. Outputs return to 0 asynchronously.
  - Deasserting reset takes effect at the next rising edge of clk_4f. The first valid lane after that is lane 0.

## Test plan
- Reset low for 4 cycles with valid toggling → all outputs 0. Release → idle, no pulses.
- Defaults, stream EE,FF,FD,CC → one cycle after CC: data_out=32'hEEFFFDCC, lane_mask=4'hF, valid_out high 1 cycle.
- Continuous AA,12,BB,00,11,22,33,44 → two pulses exactly 4 cycles apart: 32'hAA12BB00, then 32'h11223344.
- AA,12 then valid=0:
  - FLUSH_PARTIAL=1 → data_out=32'hAA120000, lane_mask=4'hC, valid_out pulse.
  - FLUSH_PARTIAL=0 → err_partial pulse; data_out and valid_out unchanged.
- AA,12, then align=1 with valid=1 data 55, then 66,77,88 → single pulse 32'h55667788, no err_partial.
- MSB_FIRST=0, EE,FF,FD,CC → 32'hCCFDFFEE.
- Separately, reset asserted after 2 lanes → no emission and outputs 0. Then EE,FF,FD,CC after release → 32'hEEFFFDCC.
